// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv sequencing controller.
package multdiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEF_CNT_W      = 6;
    localparam int DEF_MULT_STEPS = 32;
    localparam int DEF_DIV_STEPS  = 32;

endpackage

// File: rtl/multdiv_ctrl_step_counter.sv
// Iteration counter for the multdiv datapath: sync clear wins over enable.
module step_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shift/add multiplier and restoring divider datapath.
// Any start pulse outside reset restarts from LOAD; MULT has priority.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MULT_STEPS = DEF_MULT_STEPS,
    parameter int DIV_STEPS  = DEF_DIV_STEPS
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    input  logic             mult_ovf,
    output logic             dp_load,
    output logic             dp_step,
    output logic             dp_op,
    output logic [CNT_W-1:0] step_cnt,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception
);

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

    state_t state;
    state_t state_nxt;
    logic   op;
    logic   div0;
    logic   start;
    logic   start_op;
    logic   div0_nxt;
    logic   last_step;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign start_op = ctrl_MULT ? OP_MULT : OP_DIV;
    assign div0_nxt = (op == OP_DIV) & divisor_zero;

    assign last_step = (op == OP_DIV) ? (step_cnt == DIV_LAST)
                                      : (step_cnt == MULT_LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_LOAD;
        end else begin
            unique case (state)
                S_IDLE: state_nxt = S_IDLE;
                S_LOAD: state_nxt = div0_nxt ? S_DONE : S_RUN;
                S_RUN:  state_nxt = last_step ? S_DONE : S_RUN;
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // op only moves on the LOAD entry edge so it is stable per operation
    always_ff @(posedge clk) begin
        if (clr) begin
            op <= OP_MULT;
        end else if (start) begin
            op <= start_op;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div0 <= 1'b0;
        end else if (state == S_LOAD) begin
            div0 <= div0_nxt;
        end
    end

    step_counter #(
        .CNT_W(CNT_W)
    ) u_step_counter (
        .clk(clk),
        .clr(clr | (state == S_LOAD)),
        .en (state == S_RUN),
        .cnt(step_cnt)
    );

    always_comb begin
        dp_load        = 1'b0;
        dp_step        = 1'b0;
        data_resultRDY = 1'b0;
        data_exception = 1'b0;
        busy           = 1'b1;
        unique case (state)
            S_IDLE: busy = 1'b0;
            S_LOAD: dp_load = 1'b1;
            S_RUN:  dp_step = 1'b1;
            S_DONE: begin
                data_resultRDY = 1'b1;
                data_exception = (op == OP_DIV) ? div0 : mult_ovf;
            end
            default: busy = 1'b0;
        endcase
    end

    assign dp_op = op;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed plan plus random traffic
// against a cycle-index model of one operation.
module tb_multdiv_ctrl;

    localparam int CNT_W      = 6;
    localparam int MULT_STEPS = 32;
    localparam int DIV_STEPS  = 32;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             ctrl_MULT = 1'b0;
    logic             ctrl_DIV = 1'b0;
    logic             divisor_zero = 1'b0;
    logic             mult_ovf = 1'b0;
    logic             dp_load;
    logic             dp_step;
    logic             dp_op;
    logic [CNT_W-1:0] step_cnt;
    logic             busy;
    logic             data_resultRDY;
    logic             data_exception;

    int n_cmp = 0;
    int n_err = 0;

    // reference: op in flight, cycle index k within it (1 = LOAD)
    bit m_act = 0;
    int m_k = 0;
    bit m_op = 0;
    bit m_div0 = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    multdiv_ctrl #(
        .CNT_W(CNT_W),
        .MULT_STEPS(MULT_STEPS),
        .DIV_STEPS(DIV_STEPS)
    ) dut (
        .clk(clk),
        .clr(clr),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .divisor_zero(divisor_zero),
        .mult_ovf(mult_ovf),
        .dp_load(dp_load),
        .dp_step(dp_step),
        .dp_op(dp_op),
        .step_cnt(step_cnt),
        .busy(busy),
        .data_resultRDY(data_resultRDY),
        .data_exception(data_exception)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int steps_of(input bit op);
        return op ? DIV_STEPS : MULT_STEPS;
    endfunction

    function automatic int done_k();
        return m_div0 ? 2 : steps_of(m_op) + 2;
    endfunction

    task automatic model_edge();
        if (clr) begin
            m_act = 0;
            m_cnt = 0;
            m_op = 0;
            m_div0 = 0;
        end else begin
            if (m_act && m_k == 1) begin
                m_cnt = 0;
                m_div0 = m_op & divisor_zero;
            end else if (m_act && m_k >= 2 && m_k < done_k()) begin
                m_cnt++;
            end
            if (ctrl_MULT || ctrl_DIV) begin
                m_act = 1;
                m_k = 1;
                m_op = ctrl_MULT ? 1'b0 : 1'b1;
            end else if (m_act) begin
                if (m_k == done_k()) m_act = 0;
                else m_k++;
            end
        end
    endtask

    task automatic compare();
        bit e_load, e_step, e_rdy;
        e_load = m_act && m_k == 1;
        e_rdy  = m_act && m_k > 1 && m_k == done_k();
        e_step = m_act && m_k >= 2 && m_k < done_k();
        check("dp_load", 32'(dp_load), 32'(e_load));
        check("dp_step", 32'(dp_step), 32'(e_step));
        check("rdy", 32'(data_resultRDY), 32'(e_rdy));
        check("busy", 32'(busy), 32'(m_act));
        check("dp_op", 32'(dp_op), 32'(m_op));
        check("step_cnt", 32'(step_cnt), 32'(m_cnt));
        if (e_rdy) begin
            check("exception", 32'(data_exception),
                  32'(m_op ? m_div0 : mult_ovf));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    // runs from cycle 2 on; returns the cycle index of RDY or -1 on timeout
    task automatic run_ops(input int max, output int nstep,
                           output int rdy_at);
        nstep = 0;
        rdy_at = -1;
        for (int i = 2; i <= max; i++) begin
            cycle();
            if (dp_step) nstep++;
            if (data_resultRDY) begin
                rdy_at = i;
                break;
            end
        end
    endtask

    initial begin
        int ns;
        int ra;
        int seen_rdy;

        // reset held 3 cycles, then idle
        clr = 1'b1;
        repeat (3) cycle();
        check("rst_cnt", 32'(step_cnt), 32'd0);
        clr = 1'b0;
        repeat (10) cycle();
        check("idle_busy", 32'(busy), 32'd0);

        // plain multiply
        mult_ovf = 1'b0;
        ctrl_MULT = 1'b1;
        cycle();
        check("mul_load", 32'(dp_load), 32'd1);
        ctrl_MULT = 1'b0;
        run_ops(60, ns, ra);
        check("mul_steps", 32'(ns), 32'd32);
        check("mul_rdy_cyc", 32'(ra), 32'd34);
        check("mul_exc", 32'(data_exception), 32'd0);
        check("mul_cnt", 32'(step_cnt), 32'd32);
        cycle();
        check("mul_busy35", 32'(busy), 32'd0);
        repeat (2) cycle();

        // divide by zero: flag seen in LOAD only
        ctrl_DIV = 1'b1;
        divisor_zero = 1'b0;
        cycle();
        ctrl_DIV = 1'b0;
        divisor_zero = 1'b1;
        run_ops(60, ns, ra);
        divisor_zero = 1'b0;
        check("dz_steps", 32'(ns), 32'd0);
        check("dz_rdy_cyc", 32'(ra), 32'd2);
        check("dz_exc", 32'(data_exception), 32'd1);
        check("dz_op", 32'(dp_op), 32'd1);
        repeat (2) cycle();

        // multiply aborted by divide at step 10
        ctrl_MULT = 1'b1;
        cycle();
        ctrl_MULT = 1'b0;
        seen_rdy = 0;
        for (int i = 0; i < 11; i++) begin
            cycle();
            if (data_resultRDY) seen_rdy++;
        end
        check("ab_cnt10", 32'(step_cnt), 32'd10);
        ctrl_DIV = 1'b1;
        cycle();
        ctrl_DIV = 1'b0;
        check("ab_load", 32'(dp_load), 32'd1);
        check("ab_op", 32'(dp_op), 32'd1);
        run_ops(60, ns, ra);
        check("ab_no_rdy", 32'(seen_rdy), 32'd0);
        check("ab_steps", 32'(ns), 32'd32);
        check("ab_rdy_cyc", 32'(ra), 32'd34);
        repeat (2) cycle();

        // simultaneous starts, overflowing multiply
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        cycle();
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        check("both_op", 32'(dp_op), 32'd0);
        mult_ovf = 1'b1;
        run_ops(60, ns, ra);
        check("ovf_exc", 32'(data_exception), 32'd1);
        check("ovf_rdy_cyc", 32'(ra), 32'd34);
        mult_ovf = 1'b0;
        repeat (2) cycle();

        // reset mid-run at step 20, then a fresh divide
        ctrl_MULT = 1'b1;
        cycle();
        ctrl_MULT = 1'b0;
        repeat (21) cycle();
        check("cl_cnt20", 32'(step_cnt), 32'd20);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("cl_busy", 32'(busy), 32'd0);
        check("cl_cnt", 32'(step_cnt), 32'd0);
        check("cl_rdy", 32'(data_resultRDY), 32'd0);
        ctrl_DIV = 1'b1;
        cycle();
        ctrl_DIV = 1'b0;
        run_ops(60, ns, ra);
        check("cl_div_rdy", 32'(ra), 32'd34);
        check("cl_div_exc", 32'(data_exception), 32'd0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            clr = ($urandom % 150) == 0;
            ctrl_MULT = ($urandom % 45) == 0;
            ctrl_DIV = ($urandom % 45) == 0;
            divisor_zero = ($urandom % 4) == 0;
            mult_ovf = $urandom % 2;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
